// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl: PIN-entry front end for the home-alarm FSM.
// Collects four BCD digits, compares them against PIN, and issues a
// one-period arm (4'b0011) or disarm (4'b1100) command. Consecutive
// failed attempts lead to a timed lockout. Everything advances only on
// clk edges with ENA=1, except reset, which acts on any clk edge.
module keypad_code_ctrl #(
  parameter logic [15:0] PIN            = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 200,
  parameter int          ENTRY_TIMEOUT  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       is_armed,
  input  logic       is_wait_delay,
  input  logic       alarm_siren,
  output logic [3:0] keypad_cmd,
  output logic       bad_code,
  output logic       locked_out,
  output logic [2:0] digit_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_ISSUE,
    S_LOCKOUT
  } state_t;

  localparam logic [2:0] MAX_TRIES_L = 3'(MAX_TRIES);
  localparam logic [9:0] LOCK_LOAD   = 10'(LOCKOUT_CYCLES - 1);
  localparam logic [7:0] TMO_LOAD    = 8'(ENTRY_TIMEOUT - 1);
  localparam logic [3:0] CMD_ARM     = 4'b0011;
  localparam logic [3:0] CMD_DISARM  = 4'b1100;

  state_t     state_q;
  logic [15:0] code_buf_q;
  logic [2:0]  digit_cnt_q;
  logic        ovf_q;
  logic [2:0]  fail_cnt_q;
  logic [9:0]  lock_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [3:0]  cmd_q;
  logic        bad_code_q;
  logic        locked_out_q;

  logic       key_digit;
  logic       key_enter;
  logic       key_clear;
  logic       key_accepted;
  logic       code_match;
  logic       alarm_active;
  logic [2:0] fail_cnt_d;

  // Key decode, match test and saturating next fail count.
  always_comb begin
    key_digit    = key_valid && (key_code <= 4'd9);
    key_enter    = key_valid && (key_code == 4'hA);
    key_clear    = key_valid && (key_code == 4'hB);
    key_accepted = key_digit || key_enter || key_clear;
    code_match   = (digit_cnt_q == 3'd4) && !ovf_q && (code_buf_q == PIN);
    alarm_active = is_armed || is_wait_delay || alarm_siren;
    fail_cnt_d   = (fail_cnt_q != 3'd7) ? fail_cnt_q + 3'd1 : fail_cnt_q;
  end

  // Main controller FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_buf_q   <= '0;
      digit_cnt_q  <= '0;
      ovf_q        <= 1'b0;
      fail_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      cmd_q        <= '0;
      bad_code_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else if (ENA) begin
      // Command and reject pulses last exactly one ENA period.
      cmd_q      <= '0;
      bad_code_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_digit) begin
            code_buf_q  <= {code_buf_q[11:0], key_code};
            digit_cnt_q <= 3'd1;
            tmo_cnt_q   <= TMO_LOAD;
            state_q     <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (key_accepted) begin
            tmo_cnt_q <= TMO_LOAD;
          end
          if (key_digit) begin
            if (digit_cnt_q < 3'd4) begin
              code_buf_q  <= {code_buf_q[11:0], key_code};
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end else begin
              // A fifth digit poisons the entry rather than being dropped silently.
              ovf_q <= 1'b1;
            end
          end else if (key_clear) begin
            code_buf_q  <= '0;
            digit_cnt_q <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
          end else if (key_enter) begin
            state_q <= S_CHECK;
          end else if (tmo_cnt_q == 8'd0) begin
            // Abandoned partial entry: discard like a clear, no failure.
            code_buf_q  <= '0;
            digit_cnt_q <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 8'd1;
          end
        end

        S_CHECK: begin
          code_buf_q  <= '0;
          digit_cnt_q <= '0;
          ovf_q       <= 1'b0;
          if (code_match) begin
            cmd_q      <= alarm_active ? CMD_DISARM : CMD_ARM;
            fail_cnt_q <= '0;
            state_q    <= S_ISSUE;
          end else begin
            bad_code_q <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == MAX_TRIES_L) begin
              locked_out_q <= 1'b1;
              lock_cnt_q   <= LOCK_LOAD;
              state_q      <= S_LOCKOUT;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end

        S_ISSUE: begin
          state_q <= S_IDLE;
        end

        S_LOCKOUT: begin
          if (lock_cnt_q == 10'd0) begin
            locked_out_q <= 1'b0;
            fail_cnt_q   <= '0;
            state_q      <= S_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q - 10'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign keypad_cmd = cmd_q;
  assign bad_code   = bad_code_q;
  assign locked_out = locked_out_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_keypad_code_ctrl.sv
// Directed testbench for keypad_code_ctrl with default parameters.
module tb_keypad_code_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ENA;
  logic       key_valid;
  logic [3:0] key_code;
  logic       is_armed;
  logic       is_wait_delay;
  logic       alarm_siren;
  logic [3:0] keypad_cmd;
  logic       bad_code;
  logic       locked_out;
  logic [2:0] digit_cnt;

  int n_checks = 0;
  int n_fails  = 0;
  int lock_periods;

  keypad_code_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ENA          (ENA),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .is_armed     (is_armed),
    .is_wait_delay(is_wait_delay),
    .alarm_siren  (alarm_siren),
    .keypad_cmd   (keypad_cmd),
    .bad_code     (bad_code),
    .locked_out   (locked_out),
    .digit_cnt    (digit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk edge; inputs and samples both sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    press(v[15:12]);
    press(v[11:8]);
    press(v[7:4]);
    press(v[3:0]);
    press(4'hA);
  endtask

  // Enter a PIN and check the resulting one-period command or reject pulse.
  task automatic attempt(input string tag, input logic [15:0] p,
                         input logic [3:0] exp_cmd, input logic exp_bad,
                         input logic exp_lock);
    enter_pin(p);
    chk({tag, "_pre_cmd"}, 16'(keypad_cmd), 16'h0);
    step();
    chk({tag, "_cmd"}, 16'(keypad_cmd), 16'(exp_cmd));
    chk({tag, "_bad"}, 16'(bad_code), 16'(exp_bad));
    chk({tag, "_lock"}, 16'(locked_out), 16'(exp_lock));
    chk({tag, "_cnt"}, 16'(digit_cnt), 16'h0);
    step();
    chk({tag, "_cmd_end"}, 16'(keypad_cmd), 16'h0);
    chk({tag, "_bad_end"}, 16'(bad_code), 16'h0);
  endtask

  initial begin
    reset = 1'b1; ENA = 1'b1; key_valid = 1'b0; key_code = 4'h0;
    is_armed = 1'b0; is_wait_delay = 1'b0; alarm_siren = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_cmd", 16'(keypad_cmd), 16'h0);
    chk("rst_bad", 16'(bad_code), 16'h0);
    chk("rst_lock", 16'(locked_out), 16'h0);
    chk("rst_cnt", 16'(digit_cnt), 16'h0);

    // Correct PIN while disarmed arms the alarm.
    press(4'h1); press(4'h2); press(4'h3);
    chk("cnt3", 16'(digit_cnt), 16'h3);
    press(4'h4);
    chk("cnt4", 16'(digit_cnt), 16'h4);
    press(4'hA);
    chk("arm_lat", 16'(keypad_cmd), 16'h0);
    step();
    chk("arm_cmd", 16'(keypad_cmd), 16'h3);
    chk("arm_bad", 16'(bad_code), 16'h0);
    chk("arm_cnt", 16'(digit_cnt), 16'h0);
    step();
    chk("arm_end", 16'(keypad_cmd), 16'h0);

    // Any alarm status high selects disarm.
    is_armed = 1'b1;
    attempt("dis_armed", 16'h1234, 4'hC, 1'b0, 1'b0);
    is_armed = 1'b0; alarm_siren = 1'b1;
    attempt("dis_siren", 16'h1234, 4'hC, 1'b0, 1'b0);
    alarm_siren = 1'b0; is_wait_delay = 1'b1;
    attempt("dis_wait", 16'h1234, 4'hC, 1'b0, 1'b0);
    is_wait_delay = 1'b0;

    // Three wrong codes trigger lockout.
    attempt("bad1", 16'h9999, 4'h0, 1'b1, 1'b0);
    attempt("bad2", 16'h9999, 4'h0, 1'b1, 1'b0);
    enter_pin(16'h9999);
    step();
    chk("bad3_bad", 16'(bad_code), 16'h1);
    chk("bad3_lock", 16'(locked_out), 16'h1);
    lock_periods = 1;
    // Correct PIN during lockout is ignored.
    for (int i = 0; i < 5; i++) begin
      logic [19:0] seq;
      seq = 20'h1234A;
      key_valid = 1'b1;
      key_code  = seq[19 - 4*i -: 4];
      step();
      key_valid = 1'b0;
      if (locked_out) lock_periods++;
      chk("lock_nocmd", 16'(keypad_cmd), 16'h0);
    end
    chk("lock_cnt", 16'(digit_cnt), 16'h0);
    // ENA low mid-lockout freezes everything.
    ENA = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("ena_lock_hold", 16'(locked_out), 16'h1);
    ENA = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (locked_out) lock_periods++;
      else break;
    end
    chk("lock_periods", 16'(lock_periods), 16'd200);
    chk("lock_exit", 16'(locked_out), 16'h0);
    attempt("post_lock", 16'h1234, 4'h3, 1'b0, 1'b0);

    // Overflowing entry is rejected.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("ovf_cnt", 16'(digit_cnt), 16'h4);
    press(4'hA);
    step();
    chk("ovf_bad", 16'(bad_code), 16'h1);
    chk("ovf_cmd", 16'(keypad_cmd), 16'h0);
    step();
    // Clear mid-entry restarts without a failure.
    press(4'h1); press(4'h2); press(4'hB);
    chk("clr_cnt", 16'(digit_cnt), 16'h0);
    attempt("after_clr", 16'h1234, 4'h3, 1'b0, 1'b0);

    // Entry timeout discards a partial entry.
    press(4'h1); press(4'h2);
    for (int i = 0; i < 49; i++) step();
    chk("tmo_49", 16'(digit_cnt), 16'h2);
    step();
    chk("tmo_50", 16'(digit_cnt), 16'h0);
    press(4'h3); press(4'h4); press(4'hA);
    step();
    chk("tmo_bad", 16'(bad_code), 16'h1);
    step();
    attempt("fc_bad2", 16'h9999, 4'h0, 1'b1, 1'b0);
    attempt("fc_ok", 16'h1234, 4'h3, 1'b0, 1'b0);
    attempt("fc_bad_a", 16'h9999, 4'h0, 1'b1, 1'b0);
    attempt("fc_bad_b", 16'h9999, 4'h0, 1'b1, 1'b0);
    attempt("fc_bad_c", 16'h9999, 4'h0, 1'b1, 1'b1);

    // Reset during lockout, with ENA low, clears everything.
    ENA = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; ENA = 1'b1;
    chk("rst_lock_exit", 16'(locked_out), 16'h0);
    chk("rst_lock_cnt", 16'(digit_cnt), 16'h0);

    // ENA low mid-entry ignores keys and holds state.
    press(4'h1); press(4'h2);
    ENA = 1'b0; key_valid = 1'b1; key_code = 4'h3;
    for (int i = 0; i < 7; i++) step();
    key_valid = 1'b0;
    chk("ena_entry_hold", 16'(digit_cnt), 16'h2);
    ENA = 1'b1;
    press(4'h3); press(4'h4); press(4'hA);
    step();
    chk("ena_entry_cmd", 16'(keypad_cmd), 16'h3);
    chk("ena_entry_bad", 16'(bad_code), 16'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
